// File: rtl/lif_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// lif_sched_pkg: shared state encoding and default sizing for lif_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int N_DEFAULT  = 4;
  localparam int T_DEFAULT  = 16;
  localparam int Q_DEFAULT  = 8;
  localparam int DEF_THRESH = 64;

endpackage

`default_nettype wire

// File: rtl/lif_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, first request after last_grant
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Scan starts one past the previous winner so the last one served is checked last.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_grant) + off) % N;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lif_scheduler.sv
// ----------------------------------------------------------------------------
// lif_scheduler: time-shares one LIF neuron unit between N requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lif_scheduler
  import lif_sched_pkg::*;
#(
  parameter int             N          = N_DEFAULT,
  parameter int             T          = T_DEFAULT,
  parameter int             Q          = Q_DEFAULT,
  parameter int             TIMEOUT    = 2 * T,
  parameter logic [Q-1:0]   DEF_THRESH = Q'(lif_sched_pkg::DEF_THRESH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*T*Q-1:0]     req_data,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_idx,
  input  logic [Q-1:0]         cfg_thresh,
  output logic                 lif_start,
  output logic                 lif_result_val,
  output logic [T*Q-1:0]       lif_input_data,
  output logic [Q-1:0]         lif_threshold,
  input  logic [T-1:0]         lif_spike_out,
  input  logic                 lif_done,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ready,
  output logic [T-1:0]         resp_spikes,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 clr_err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         job_id_q, job_id_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [T*Q-1:0]        job_data_q, job_data_d;
  logic [Q-1:0]          job_thr_q, job_thr_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [T-1:0]          resp_spikes_q, resp_spikes_d;
  logic                  resp_err_q, resp_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [N-1:0][Q-1:0]   thr_q, thr_d;

  logic [N-1:0]          gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  arb_en;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(.N(N)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d       = state_q;
    job_id_d      = job_id_q;
    last_grant_d  = last_grant_q;
    job_data_d    = job_data_q;
    job_thr_d     = job_thr_q;
    wait_cnt_d    = wait_cnt_q;
    resp_spikes_d = resp_spikes_q;
    resp_err_d    = resp_err_q;
    timeout_err_d = timeout_err_q;
    thr_d         = thr_q;

    if (cfg_we && (int'(cfg_idx) < N)) thr_d[cfg_idx] = cfg_thresh;
    if (clr_err) timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          job_id_d   = gnt_idx;
          job_data_d = req_data[int'(gnt_idx)*T*Q +: T*Q];
          // Reads the pre-write value, so a same-cycle write affects only later jobs.
          job_thr_d  = thr_q[gnt_idx];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (lif_done) begin
          resp_spikes_d = lif_spike_out;
          resp_err_d    = 1'b0;
          state_d       = RESP;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          resp_spikes_d = '0;
          resp_err_d    = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (resp_ready[job_id_q]) begin
          last_grant_d = job_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      job_id_q      <= '0;
      last_grant_q  <= IW'(N - 1);
      job_data_q    <= '0;
      job_thr_q     <= DEF_THRESH;
      wait_cnt_q    <= '0;
      resp_spikes_q <= '0;
      resp_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      thr_q         <= {N{DEF_THRESH}};
    end else begin
      state_q       <= state_d;
      job_id_q      <= job_id_d;
      last_grant_q  <= last_grant_d;
      job_data_q    <= job_data_d;
      job_thr_q     <= job_thr_d;
      wait_cnt_q    <= wait_cnt_d;
      resp_spikes_q <= resp_spikes_d;
      resp_err_q    <= resp_err_d;
      timeout_err_q <= timeout_err_d;
      thr_q         <= thr_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[job_id_q] = 1'b1;
  end

  assign req_ready      = gnt;
  assign lif_start      = (state_q == ISSUE);
  assign lif_result_val = (state_q == ISSUE);
  assign lif_input_data = job_data_q;
  assign lif_threshold  = job_thr_q;
  assign resp_spikes    = resp_spikes_q;
  assign resp_err       = resp_err_q;
  assign busy           = (state_q != IDLE);
  assign timeout_err    = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lif_scheduler: scoreboard bench with a toy LIF stub behind the scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lif_scheduler;

  localparam int N = 4, T = 16, Q = 8, TIMEOUT = 2 * T;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*T*Q-1:0] req_data;
  logic             cfg_we, clr_err;
  logic [1:0]       cfg_idx;
  logic [Q-1:0]     cfg_thresh, lif_threshold;
  logic             lif_start, lif_result_val, lif_done, resp_err, busy, timeout_err;
  logic [T*Q-1:0]   lif_input_data;
  logic [T-1:0]     lif_spike_out, resp_spikes;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic stub_en;

  typedef struct { int idx; logic [T-1:0] spikes; logic err; int lat; } exp_t;
  typedef struct { int idx; int cyc; } gnt_t;
  exp_t exp_q[$];
  gnt_t gnt_q[$];

  lif_scheduler #(.N(N), .T(T), .Q(Q), .TIMEOUT(TIMEOUT), .DEF_THRESH(8'd64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_thresh(cfg_thresh),
    .lif_start(lif_start), .lif_result_val(lif_result_val), .lif_input_data(lif_input_data),
    .lif_threshold(lif_threshold), .lif_spike_out(lif_spike_out), .lif_done(lif_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_spikes(resp_spikes),
    .resp_err(resp_err), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Toy neuron: membrane gains twice the input each step, fires and resets at threshold.
  function automatic logic [T-1:0] toy_lif(input logic [T*Q-1:0] d, input logic [Q-1:0] th);
    int v = 0;
    logic [T-1:0] s = '0;
    for (int i = 0; i < T; i++) begin
      v += 2 * int'(d[i*Q +: Q]);
      if (v >= int'(th)) begin s[i] = 1'b1; v = 0; end
    end
    return s;
  endfunction

  int unsigned    stub_cnt;
  logic [T*Q-1:0] stub_data;
  logic [Q-1:0]   stub_thr;

  // LIF stub: lif_done arrives T+2 cycles after the start cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= 0; lif_done <= 1'b0; lif_spike_out <= '0;
    end else begin
      lif_done <= 1'b0;
      if (lif_start) begin
        stub_cnt <= 1; stub_data <= lif_input_data; stub_thr <= lif_threshold;
      end else if (stub_cnt != 0) begin
        if (stub_cnt == T + 1) begin
          stub_cnt <= 0;
          if (stub_en) begin
            lif_done      <= 1'b1;
            lif_spike_out <= toy_lif(stub_data, stub_thr);
          end
        end else stub_cnt <= stub_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin : grant_watch
    gnt_t g;
    if (rst_n && (req_ready !== '0)) begin
      chk("req_ready_onehot", 32'($onehot(req_ready)), 1);
      chk("grant_to_valid", 32'(|(req_ready & req_valid)), 1);
      g.idx = idx_of(req_ready);
      g.cyc = cyc;
      gnt_q.push_back(g);
    end
  end

  logic prev_rv = 1'b0;
  always @(negedge clk) begin : resp_monitor
    exp_t e;
    gnt_t g;
    if (!rst_n) prev_rv = 1'b0;
    else begin
      if ((resp_valid !== '0) && !prev_rv) begin
        if (exp_q.size() == 0 || gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response: resp_valid=%b with empty scoreboard", resp_valid);
        end else chk("resp_latency", cyc - gnt_q[0].cyc, exp_q[0].lat);
      end
      if (((resp_valid & resp_ready) !== '0) && exp_q.size() != 0 && gnt_q.size() != 0) begin
        e = exp_q.pop_front();
        g = gnt_q.pop_front();
        chk("grant_idx", g.idx, e.idx);
        chk("resp_valid_onehot", resp_valid, 1 << e.idx);
        chk("resp_spikes", resp_spikes, e.spikes);
        chk("resp_err", resp_err, e.err);
      end
      prev_rv = (resp_valid !== '0);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_data(input int idx, input logic [Q-1:0] b);
    for (int i = 0; i < T; i++) req_data[(idx*T + i)*Q +: Q] = b;
  endtask

  task automatic push_exp(input int idx, input logic [T-1:0] s, input logic e, input int lat);
    exp_t x;
    x.idx = idx; x.spikes = s; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_grant(output int idx, output int gcyc);
    idx = -1; gcyc = 0;
    for (int n = 0; n < 200 && idx < 0; n++) begin
      @(negedge clk);
      if (req_ready !== '0) begin idx = idx_of(req_ready); gcyc = cyc; end
    end
    if (idx < 0) begin checks++; errors++; $display("FAIL grant_wait: no grant within 200 cycles"); end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    if (!done) begin checks++; errors++; $display("FAIL idle_wait: busy stuck high for 200 cycles"); end
  endtask

  task automatic wait_resp(input int idx);
    bit done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (resp_valid[idx] === 1'b1) done = 1;
    end
    if (!done) begin checks++; errors++; $display("FAIL resp_wait: resp_valid[%0d] never rose", idx); end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_lif_start"}, lif_start, 0);
    chk({tag, "_lif_result_val"}, lif_result_val, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_spikes"}, resp_spikes, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_lif_input_nonzero"}, 32'(|lif_input_data), 0);
    chk({tag, "_lif_threshold"}, lif_threshold, 64);
  endtask

  initial begin
    int g, gc, prev_gc, set_cyc;
    req_valid = '0; resp_ready = '1; req_data = '0; cfg_we = 0; cfg_idx = '0;
    cfg_thresh = '0; clr_err = 0; stub_en = 1; prev_gc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1;
    tick();

    // All four requesters valid: 0,1,2,3,0 at one job per T+5 cycles.
    set_data(0, 8'd20); set_data(1, 8'd40); set_data(2, 8'd10); set_data(3, 8'd0);
    push_exp(0, 16'hAAAA, 0, 20); push_exp(1, 16'hFFFF, 0, 20);
    push_exp(2, 16'h8888, 0, 20); push_exp(3, 16'h0000, 0, 20);
    push_exp(0, 16'hAAAA, 0, 20);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, gc);
      chk("rr_order", g, k % 4);
      if (k > 0) chk("job_period", gc - prev_gc, T + 5);
      prev_gc = gc;
    end
    tick(); req_valid = '0;
    wait_idle();

    // Single job on requester 2, with ISSUE pulse and stable LIF inputs.
    set_data(2, 8'd20); push_exp(2, 16'hAAAA, 0, 20);
    tick(); req_valid[2] = 1;
    wait_grant(g, gc); chk("single_grant", g, 2);
    tick(); req_valid[2] = 0;
    @(negedge clk);
    chk("ready_pulse_low", req_ready, 0);
    chk("lif_start_issue", lif_start, 1);
    @(negedge clk);
    chk("lif_start_one_cycle", lif_start, 0);
    chk("lif_thr_job", lif_threshold, 64);
    chk("lif_input_step5", lif_input_data[5*Q +: Q], 20);
    wait_idle();

    // Threshold write in the grant cycle: old value used now, new value next time.
    set_data(1, 8'd20); push_exp(1, 16'hAAAA, 0, 20);
    tick(); set_cyc = cyc;
    req_valid[1] = 1; cfg_we = 1; cfg_idx = 2'd1; cfg_thresh = 8'd10;
    wait_grant(g, gc); chk("race_grant", g, 1); chk("race_same_cycle", gc, set_cyc);
    tick(); cfg_we = 0; req_valid[1] = 0;
    @(negedge clk); chk("race_thr_old", lif_threshold, 64);
    wait_idle();
    push_exp(1, 16'hFFFF, 0, 20);
    tick(); req_valid[1] = 1;
    wait_grant(g, gc); tick(); req_valid[1] = 0;
    @(negedge clk); chk("race_thr_new", lif_threshold, 10);
    wait_idle();

    // Backpressure on requester 0 while requester 3 waits.
    set_data(0, 8'd20); set_data(3, 8'd0);
    push_exp(0, 16'hAAAA, 0, 20); push_exp(3, 16'h0000, 0, 20);
    tick(); resp_ready[0] = 0; req_valid[0] = 1;
    wait_grant(g, gc); chk("hold_grant", g, 0);
    tick(); req_valid[0] = 0; req_valid[3] = 1;
    wait_resp(0);
    repeat (10) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 4'b0001);
      chk("hold_resp_spikes", resp_spikes, 16'hAAAA);
      chk("hold_busy", busy, 1);
      chk("hold_no_grant", req_ready, 0);
    end
    tick(); resp_ready[0] = 1;
    wait_grant(g, gc); chk("after_hold_grant", g, 3);
    tick(); req_valid[3] = 0;
    wait_idle();

    // Watchdog: LIF never finishes.
    stub_en = 0;
    set_data(2, 8'd20); push_exp(2, 16'h0000, 1, 34);
    tick(); req_valid[2] = 1;
    wait_grant(g, gc); tick(); req_valid[2] = 0;
    wait_idle();
    repeat (3) begin @(negedge clk); chk("timeout_sticky", timeout_err, 1); end
    tick(); clr_err = 1; tick(); clr_err = 0;
    @(negedge clk); chk("timeout_cleared", timeout_err, 0);

    // Watchdog and clr_err in the same cycle: the set wins.
    push_exp(3, 16'h0000, 1, 34);
    tick(); req_valid[3] = 1;
    wait_grant(g, gc); tick(); req_valid[3] = 0;
    for (int n = 0; n < 60 && cyc < gc + 33; n++) tick();
    clr_err = 1; tick(); clr_err = 0;
    @(negedge clk); chk("timeout_set_wins", timeout_err, 1);
    wait_idle();
    tick(); clr_err = 1; tick(); clr_err = 0;
    stub_en = 1;

    // Reset in the middle of WAIT aborts the job without a response.
    set_data(1, 8'd20);
    tick(); req_valid[1] = 1;
    wait_grant(g, gc); tick(); req_valid[1] = 0;
    repeat (5) tick();
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_thr", lif_threshold, 10);
    #2; rst_n = 0; #1;
    check_reset_outputs("midjob");
    gnt_q.delete();
    @(posedge clk); #1; rst_n = 1;
    push_exp(1, 16'hAAAA, 0, 20);
    tick(); req_valid[1] = 1;
    wait_grant(g, gc); chk("post_reset_grant", g, 1);
    tick(); req_valid[1] = 0;
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
